// File: rtl/tcdm_copy_pkg.sv
// tcdm_copy_pkg: shared state encoding and bus constants for the TCDM copy master
package tcdm_copy_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} tcdm_copy_state_e;
    localparam int TCDM_WORD_BYTES = 4;
    localparam logic [3:0] TCDM_BE_FULL = 4'hF;
endpackage

// File: rtl/tcdm_copy_master.sv
// tcdm_copy_master: TCDM word copier, one read then one write per word, one transaction in flight
// Defining TCDM_COPY_OPC_CHECK_EN makes a response with r_opc=1 abort the copy and raise err_o.
module tcdm_copy_master
    import tcdm_copy_pkg::*;
#(
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  words_done_o,
    output logic                  tcdm_req_o,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [31:0]           tcdm_wdata_o,
    output logic [3:0]            tcdm_be_o,
    input  logic                  tcdm_gnt_i,
    input  logic                  tcdm_r_valid_i,
    input  logic [31:0]           tcdm_r_rdata_i,
    input  logic                  tcdm_r_opc_i
);
    tcdm_copy_state_e      state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q;
    logic [31:0]           buf_q;
    logic                  opc_err;
    logic                  accept;

    assign accept = state_q == IDLE && start_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = len_i != '0 ? RD_REQ : FINISH;
            RD_REQ:  if (tcdm_gnt_i) state_d = RD_WAIT;
            RD_WAIT: if (tcdm_r_valid_i) state_d = opc_err ? FINISH : WR_REQ;
            WR_REQ:  if (tcdm_gnt_i) state_d = WR_WAIT;
            WR_WAIT: if (tcdm_r_valid_i)
                state_d = (opc_err || LEN_WIDTH'(cnt_q + 1'b1) == len_q) ? FINISH : RD_REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) cnt_q <= '0;
            if (accept && len_i != '0) begin
                src_q <= {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
                dst_q <= {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
                len_q <= len_i;
            end
            if (state_q == RD_WAIT && tcdm_r_valid_i) buf_q <= tcdm_r_rdata_i;
            if (state_q == WR_WAIT && tcdm_r_valid_i && !opc_err) begin
                cnt_q <= cnt_q + 1'b1;
                src_q <= src_q + ADDR_WIDTH'(TCDM_WORD_BYTES);
                dst_q <= dst_q + ADDR_WIDTH'(TCDM_WORD_BYTES);
            end
        end
    end

`ifdef TCDM_COPY_OPC_CHECK_EN
    logic err_q;
    assign opc_err = tcdm_r_opc_i;
    assign err_o   = err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if ((state_q == RD_WAIT || state_q == WR_WAIT) && tcdm_r_valid_i && tcdm_r_opc_i) err_q <= 1'b1;
    end
`else
    logic opc_unused;
    assign opc_unused = tcdm_r_opc_i;
    assign opc_err    = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign tcdm_req_o   = state_q == RD_REQ || state_q == WR_REQ;
    assign tcdm_wen_o   = state_q != WR_REQ;
    assign tcdm_add_o   = tcdm_wen_o ? src_q : dst_q;
    assign tcdm_wdata_o = buf_q;
    assign tcdm_be_o    = TCDM_BE_FULL;
    assign busy_o       = state_q != IDLE && state_q != FINISH;
    assign done_o       = state_q == FINISH;
    assign words_done_o = cnt_q;
endmodule

// File: doc/tcdm_copy_master.md
Name: tcdm_copy_master

Overview:
- TCDM bus initiator that copies a block of 32-bit words from a source region to a destination region. Typical use: boot code from the boot ROM into L2.
- Drives the master side of the XBAR_TCDM_BUS protocol: req/gnt address phase, r_valid response phase.
- One outstanding transaction at a time: read word, write word, repeat.
- Sits in the SoC next to the FC/debug boot path; software or a boot FSM configures it through plain input ports.

Parameters:
- LEN_WIDTH, 16, width of the word-count input and internal counter.
- ADDR_WIDTH, 32, TCDM address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; latches src/dst/len and starts the copy.
- src_addr_i  in  ADDR_WIDTH  source byte address; bits [1:0] ignored.
- dst_addr_i  in  ADDR_WIDTH  destination byte address; bits [1:0] ignored.
- len_i  in  LEN_WIDTH  number of 32-bit words to copy.
- busy_o  out  1  high from the cycle after an accepted start until the cycle done_o is high.
- done_o  out  1  one-cycle pulse when the copy ends (normally or on error).
- err_o  out  1  sticky error flag; cleared by the next accepted start.
- words_done_o  out  LEN_WIDTH  count of words fully written in the current or last copy.
- tcdm_req_o  out  1  request.
- tcdm_add_o  out  ADDR_WIDTH  byte address, bits [1:0] = 0.
- tcdm_wen_o  out  1  1 = read, 0 = write.
- tcdm_wdata_o  out  32  write data.
- tcdm_be_o  out  4  byte enables; always 4'hF.
- tcdm_gnt_i  in  1  grant.
- tcdm_r_valid_i  in  1  response valid (reads and writes).
- tcdm_r_rdata_i  in  32  read data.
- tcdm_r_opc_i  in  1  response error flag.

Behaviour:
- Reset values: all outputs 0 except tcdm_wen_o=1 and tcdm_be_o=4'hF. FSM goes to IDLE; counters, address registers and data buffer are cleared. Reset mid-copy abandons the transfer immediately, with no done_o.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE:
  - start_i with len_i!=0: latch the word-aligned addresses and len; clear err_o and words_done_o; go to RD_REQ.
  - start_i with len_i==0: go to FINISH. done_o pulses exactly one cycle later; no bus activity.
- RD_REQ: req=1, wen=1, add=src. Address, wen and wdata stay stable until gnt. On req&&gnt go to RD_WAIT.
- RD_WAIT: req=0. On r_valid, capture r_rdata into the buffer and go to WR_REQ. r_valid may arrive one or more cycles after gnt; the boot ROM returns it exactly one cycle after gnt.
- WR_REQ: req=1, wen=0, add=dst, wdata=buffer. On gnt go to WR_WAIT.
- WR_WAIT: on r_valid:
  - increment words_done_o;
  - src += 4 and dst += 4, modulo 2^ADDR_WIDTH (wrap, no error);
  - if words_done_o+1 == len go to FINISH, else go to RD_REQ.
- FINISH: done_o=1 for one cycle, busy_o=0 in the same cycle, then IDLE.
- Throughput: minimum 4 cycles per word with zero-wait gnt and 1-cycle r_valid.
- start_i while busy is ignored; latched parameters are unaffected.
- r_valid outside a WAIT state is ignored.
- Without the optional feature, tcdm_r_opc_i is ignored; err_o stays 0.

Optional Feature:
- Macro: TCDM_COPY_OPC_CHECK_EN.
- Defined: r_valid with r_opc=1 in RD_WAIT or WR_WAIT sets err_o and jumps to FINISH.
  - No write is issued for the failed read.
  - words_done_o holds the count of words completed before the error.
- Not defined: r_opc has no effect; err_o is tied to 0.

Decomposition:
- Package tcdm_copy_pkg:
  - state enum tcdm_copy_state_e (the six states);
  - localparam TCDM_WORD_BYTES=4;
  - localparam TCDM_BE_FULL=4'hF.
- No sub-module; a single FSM with address, length and data registers.

Test Plan:
- Basic copy: zero-wait gnt, 1-cycle r_valid memory model; src=0x1A00_0000, dst=0x1C00_0000, len=4 -> dst words equal src words; 16 bus cycles; done_o once; words_done_o=4.
- Zero length: start with len=0 -> no req ever; done_o pulses exactly one cycle after start; busy_o never set high.
- Backpressure: gnt withheld 3 cycles per request, r_valid delayed 2 cycles -> add, wen and wdata stable while req && !gnt; data copied correctly for len=3.
- Wrap and start-while-busy: src=0xFFFF_FFF8, len=3 -> reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. A second start during the copy changes nothing.
- Reset mid-copy: rst_ni asserted in WR_WAIT of word 2 -> all outputs at reset values; a following start with len=2 completes normally.
- Opc error (feature on): r_opc=1 on the read of word 1 -> err_o=1; done_o pulses; words_done_o=1; no write to dst+4. Feature off: same stimulus completes all words with err_o=0.
